vpu_lane_engine: RTL and testbench

Parametrised multi-lane vector execution engine, successor to `vpu_unit`. It accepts one whole-vector request over a valid/ready handshake and processes `NUM_LANES` elements per cycle for `ceil(vl/NUM_LANES)` beats. It adds selectable element width (SEW), per-element masking, tail zeroing and signed min/max. It returns the full result vector over a valid/ready response channel and sits between the core's vector issue logic and the vector register file writeback.

---
 rtl/riscv_vpu_types_pkg.sv | 89 ++++++++
 rtl/vpu_lane_alu.sv | 14 +
 rtl/vpu_lane_engine.sv | 201 ++++++++++++++++++++
 tb/tb_vpu_lane_engine.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_vpu_types_pkg.sv
// Shared types, constants and element arithmetic for the multi-lane vector engine.
// The single-element operation lives here so ALU lanes and the reduction fold share one definition.
package riscv_vpu_types_pkg;

   localparam int ELEN = 32;

   typedef enum logic [3:0] {
      OP_ADD     = 4'h0,
      OP_SUB     = 4'h1,
      OP_MUL     = 4'h2,
      OP_MIN     = 4'h3,
      OP_MAX     = 4'h4,
      OP_AND     = 4'h5,
      OP_OR      = 4'h6,
      OP_XOR     = 4'h7,
      OP_REDSUM  = 4'h8,
      OP_REDMIN  = 4'h9,
      OP_REDMAX  = 4'hA,
      OP_PERMUTE = 4'hB
   } vpu_lane_op_e;

   typedef enum logic [1:0] {
      SEW_8   = 2'b00,
      SEW_16  = 2'b01,
      SEW_32  = 2'b10,
      SEW_BAD = 2'b11
   } vpu_sew_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } vpu_lane_state_e;

   function automatic logic [ELEN-1:0] sew_mask(vpu_sew_e sew);
      logic [ELEN-1:0] m;
      case (sew)
         SEW_8:   m = 32'h0000_00FF;
         SEW_16:  m = 32'h0000_FFFF;
         default: m = 32'hFFFF_FFFF;
      endcase
      return m;
   endfunction

   function automatic logic signed [ELEN-1:0] sew_sext(vpu_sew_e sew, logic [ELEN-1:0] v);
      logic signed [ELEN-1:0] s;
      case (sew)
         SEW_8:   s = {{24{v[7]}}, v[7:0]};
         SEW_16:  s = {{16{v[15]}}, v[15:0]};
         default: s = v;
      endcase
      return s;
   endfunction

   // Reduction start value: +max for MIN, most negative for MAX, zero-extended at SEW.
   function automatic logic [ELEN-1:0] sew_identity(vpu_lane_op_e op, vpu_sew_e sew);
      logic [ELEN-1:0] m;
      logic [ELEN-1:0] id;
      m = sew_mask(sew);
      case (op)
         OP_REDMIN: id = m >> 1;
         OP_REDMAX: id = m & ~(m >> 1);
         default:   id = '0;
      endcase
      return id;
   endfunction

   function automatic logic [ELEN-1:0] lane_op(vpu_lane_op_e op, vpu_sew_e sew,
                                                logic [ELEN-1:0] a, logic [ELEN-1:0] b);
      logic signed [ELEN-1:0] sa;
      logic signed [ELEN-1:0] sb;
      logic [ELEN-1:0] r;
      sa = sew_sext(sew, a);
      sb = sew_sext(sew, b);
      case (op)
         OP_ADD, OP_REDSUM: r = a + b;
         OP_SUB:            r = a - b;
         OP_MUL:            r = a * b;
         OP_MIN, OP_REDMIN: r = (sa < sb) ? a : b;
         OP_MAX, OP_REDMAX: r = (sa > sb) ? a : b;
         OP_AND:            r = a & b;
         OP_OR:             r = a | b;
         OP_XOR:            r = a ^ b;
         default:           r = a;
      endcase
      return r & sew_mask(sew);
   endfunction

endpackage

// File: rtl/vpu_lane_alu.sv
// Combinational single-element lane: applies one vector op at the selected SEW.
module vpu_lane_alu
   import riscv_vpu_types_pkg::*;
(
   input  logic [3:0]      op_i,
   input  logic [1:0]      sew_i,
   input  logic [ELEN-1:0] a_i,
   input  logic [ELEN-1:0] b_i,
   output logic [ELEN-1:0] y_o
);

   assign y_o = lane_op(vpu_lane_op_e'(op_i), vpu_sew_e'(sew_i), a_i, b_i);

endmodule

// File: rtl/vpu_lane_engine.sv
// Multi-lane vector engine: latches one whole-vector request, processes NUM_LANES elements per beat.
// state | meaning
// IDLE  | ready for a request
// EXEC  | one beat of NUM_LANES elements per cycle
// RESP  | result/error held until the consumer accepts
module vpu_lane_engine
   import riscv_vpu_types_pkg::*;
#(
   parameter int MAX_VL    = 8,
   parameter int NUM_LANES = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic [3:0]                   req_opcode_i,
   input  logic [1:0]                   req_sew_i,
   input  logic [$clog2(MAX_VL+1)-1:0]  req_vl_i,
   input  logic                         req_mask_en_i,
   input  logic [MAX_VL-1:0]            req_mask_i,
   input  logic [MAX_VL*ELEN-1:0]       req_op1_i,
   input  logic [MAX_VL*ELEN-1:0]       req_op2_i,
   output logic                         rsp_valid_o,
   input  logic                         rsp_ready_i,
   output logic [MAX_VL*ELEN-1:0]       rsp_result_o,
   output logic                         rsp_error_o,
   output logic                         busy_o
);

   localparam int VLW = $clog2(MAX_VL+1);
   localparam int IW  = (MAX_VL > 1) ? $clog2(MAX_VL) : 1;

   vpu_lane_state_e  state_q, state_d;
   vpu_lane_op_e     op_q, op_d;
   vpu_sew_e         sew_q, sew_d;
   logic             req_ready_q, req_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             err_q, err_d;
   logic             mask_en_q, mask_en_d;
   logic [VLW-1:0]   vl_q, vl_d, cnt_q, cnt_d;
   logic [MAX_VL-1:0] mask_q, mask_d;
   logic [ELEN-1:0]  acc_q, acc_d;
   logic [ELEN-1:0]  op1_q [MAX_VL];
   logic [ELEN-1:0]  op1_d [MAX_VL];
   logic [ELEN-1:0]  op2_q [MAX_VL];
   logic [ELEN-1:0]  op2_d [MAX_VL];
   logic [ELEN-1:0]  res_q [MAX_VL];
   logic [ELEN-1:0]  res_d [MAX_VL];

   logic [ELEN-1:0]  alu_a [NUM_LANES];
   logic [ELEN-1:0]  alu_b [NUM_LANES];
   logic [ELEN-1:0]  alu_y [NUM_LANES];
   logic [IW-1:0]    lane_sel [NUM_LANES];
   logic [NUM_LANES-1:0] lane_in_vl, lane_act;

   // Lane operand selection; PERMUTE gathers op1 through the op2 index before the ALU.
   always_comb begin
      logic [VLW-1:0]  e;
      logic [ELEN-1:0] pidx;
      e    = '0;
      pidx = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         e             = cnt_q + VLW'(l);
         lane_sel[l]   = e[IW-1:0];
         lane_in_vl[l] = (e < vl_q);
         lane_act[l]   = lane_in_vl[l] && (!mask_en_q || mask_q[e[IW-1:0]]);
         pidx          = op2_q[e[IW-1:0]] & sew_mask(sew_q);
         alu_b[l]      = op2_q[e[IW-1:0]];
         if (op_q == OP_PERMUTE)
            alu_a[l] = (pidx < {{(ELEN-VLW){1'b0}}, vl_q}) ? op1_q[pidx[IW-1:0]] : '0;
         else
            alu_a[l] = op1_q[e[IW-1:0]];
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      vpu_lane_alu u_alu (
         .op_i  (op_q),
         .sew_i (sew_q),
         .a_i   (alu_a[g]),
         .b_i   (alu_b[g]),
         .y_o   (alu_y[g])
      );
   end

   always_comb begin
      logic            is_red;
      logic            req_err;
      logic [ELEN-1:0] fold;
      logic [VLW-1:0]  cnt_nxt;
      state_d     = state_q;
      op_d        = op_q;
      sew_d       = sew_q;
      rsp_valid_d = rsp_valid_q;
      err_d       = err_q;
      mask_en_d   = mask_en_q;
      vl_d        = vl_q;
      cnt_d       = cnt_q;
      mask_d      = mask_q;
      acc_d       = acc_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      res_d       = res_q;
      is_red      = (op_q == OP_REDSUM) || (op_q == OP_REDMIN) || (op_q == OP_REDMAX);
      req_err     = (req_opcode_i > 4'hB) || (req_sew_i == 2'b11) || (req_vl_i > VLW'(MAX_VL));
      fold        = acc_q;
      cnt_nxt     = cnt_q + VLW'(NUM_LANES);
      case (state_q)
         ST_IDLE: begin
            rsp_valid_d = 1'b0;
            if (req_valid_i) begin
               op_d      = vpu_lane_op_e'(req_opcode_i);
               sew_d     = vpu_sew_e'(req_sew_i);
               vl_d      = req_vl_i;
               mask_en_d = req_mask_en_i;
               mask_d    = req_mask_i;
               err_d     = req_err;
               cnt_d     = '0;
               acc_d     = sew_identity(vpu_lane_op_e'(req_opcode_i), vpu_sew_e'(req_sew_i));
               for (int i = 0; i < MAX_VL; i++) begin
                  op1_d[i] = req_op1_i[i*ELEN +: ELEN];
                  op2_d[i] = req_op2_i[i*ELEN +: ELEN];
                  res_d[i] = '0;
               end
               state_d = (req_err || (req_vl_i == '0)) ? ST_RESP : ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (is_red) begin
               for (int l = 0; l < NUM_LANES; l++)
                  if (lane_act[l]) fold = lane_op(op_q, sew_q, fold, op1_q[lane_sel[l]]);
               acc_d    = fold;
               res_d[0] = fold;
            end else begin
               for (int l = 0; l < NUM_LANES; l++)
                  if (lane_in_vl[l])
                     res_d[lane_sel[l]] = lane_act[l] ? alu_y[l]
                                                      : (op1_q[lane_sel[l]] & sew_mask(sew_q));
            end
            cnt_d = cnt_nxt;
            if (cnt_nxt >= vl_q) state_d = ST_RESP;
         end
         ST_RESP: begin
            // Valid rises one cycle after entering RESP, then holds until the handshake.
            if (rsp_valid_q && rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      req_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_ADD;
         sew_q       <= SEW_8;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         err_q       <= 1'b0;
         mask_en_q   <= 1'b0;
         vl_q        <= '0;
         cnt_q       <= '0;
         mask_q      <= '0;
         acc_q       <= '0;
         for (int i = 0; i < MAX_VL; i++) res_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         sew_q       <= sew_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         err_q       <= err_d;
         mask_en_q   <= mask_en_d;
         vl_q        <= vl_d;
         cnt_q       <= cnt_d;
         mask_q      <= mask_d;
         acc_q       <= acc_d;
         res_q       <= res_d;
      end
   end

   always_ff @(posedge clk_i) begin
      op1_q <= op1_d;
      op2_q <= op2_d;
   end

   for (genvar g = 0; g < MAX_VL; g++) begin : g_out
      assign rsp_result_o[g*ELEN +: ELEN] = res_q[g];
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_error_o = err_q;
   assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vpu_lane_engine.sv
// Self-checking bench for vpu_lane_engine: directed cases plus random requests against a behavioural model.
module tb_vpu_lane_engine;

   localparam int MAX_VL    = 8;
   localparam int NUM_LANES = 2;
   localparam int VW        = MAX_VL * 32;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          req_valid_i;
   logic          req_ready_o;
   logic [3:0]    req_opcode_i;
   logic [1:0]    req_sew_i;
   logic [3:0]    req_vl_i;
   logic          req_mask_en_i;
   logic [7:0]    req_mask_i;
   logic [VW-1:0] req_op1_i;
   logic [VW-1:0] req_op2_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [VW-1:0] rsp_result_o;
   logic          rsp_error_o;
   logic          busy_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   vpu_lane_engine #(.MAX_VL(MAX_VL), .NUM_LANES(NUM_LANES)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_opcode_i  (req_opcode_i),
      .req_sew_i     (req_sew_i),
      .req_vl_i      (req_vl_i),
      .req_mask_en_i (req_mask_en_i),
      .req_mask_i    (req_mask_i),
      .req_op1_i     (req_op1_i),
      .req_op2_i     (req_op2_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_result_o  (rsp_result_o),
      .rsp_error_o   (rsp_error_o),
      .busy_o        (busy_o)
   );

   task automatic chk_v(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [VW-1:0] mk(input logic [31:0] e0, e1, e2, e3, e4, e5, e6, e7);
      return {e7, e6, e5, e4, e3, e2, e1, e0};
   endfunction

   function automatic logic [VW-1:0] rnd_vec();
      logic [VW-1:0] v;
      for (int i = 0; i < MAX_VL; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic longint sx(input longint v, input longint w);
      longint half;
      half = longint'(1) <<< (w - 1);
      return (v >= half) ? v - 2 * half : v;
   endfunction

   function automatic longint ue(input logic [VW-1:0] v, input int i, input longint m);
      return longint'(v[i*32 +: 32]) & m;
   endfunction

   // Expected response computed from element-level arithmetic on whole vectors.
   function automatic logic [VW-1:0] model(input int op, input int sew, input int vl, input bit men,
                                           input logic [7:0] mask, input logic [VW-1:0] a,
                                           input logic [VW-1:0] b, output bit err);
      logic [VW-1:0] r;
      longint w, md, m, acc, x, y, v;
      r   = '0;
      err = (op > 11) || (sew == 3) || (vl > MAX_VL);
      if (err || vl == 0) return r;
      w  = 8 << sew;
      md = longint'(1) <<< w;
      m  = md - 1;
      if (op >= 8 && op <= 10) begin
         acc = (op == 8) ? 0 : (op == 9) ? md / 2 - 1 : -(md / 2);
         for (int i = 0; i < vl; i++) begin
            if (!men || mask[i]) begin
               x = sx(ue(a, i, m), w);
               if (op == 8) acc = acc + x;
               else if (op == 9) acc = (x < acc) ? x : acc;
               else acc = (x > acc) ? x : acc;
            end
         end
         r[31:0] = 32'(acc & m);
         return r;
      end
      for (int i = 0; i < MAX_VL; i++) begin
         x = ue(a, i, m);
         y = ue(b, i, m);
         if (i >= vl) v = 0;
         else if (men && !mask[i]) v = x;
         else begin
            case (op)
               0: v = x + y;
               1: v = x - y;
               2: v = x * y;
               3: v = (sx(x, w) <= sx(y, w)) ? x : y;
               4: v = (sx(x, w) >= sx(y, w)) ? x : y;
               5: v = x & y;
               6: v = x | y;
               7: v = x ^ y;
               default: v = (y < vl) ? ue(a, int'(y), m) : 0;
            endcase
         end
         r[i*32 +: 32] = 32'(v & m);
      end
      return r;
   endfunction

   task automatic send(input string tag, input int op, input int sew, input int vl, input bit men,
                       input logic [7:0] mask, input logic [VW-1:0] a, input logic [VW-1:0] b,
                       input int hold);
      logic [VW-1:0] exp;
      bit            err;
      int            lat, exp_lat, n;
      exp     = model(op, sew, vl, men, mask, a, b, err);
      exp_lat = (err || vl == 0) ? 1 : (vl + NUM_LANES - 1) / NUM_LANES + 1;
      n = 0;
      while (!req_ready_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      chk_i({tag, " ready"}, int'(req_ready_o), 1);
      req_valid_i   = 1'b1;
      req_opcode_i  = 4'(op);
      req_sew_i     = 2'(sew);
      req_vl_i      = 4'(vl);
      req_mask_en_i = men;
      req_mask_i    = mask;
      req_op1_i     = a;
      req_op2_i     = b;
      @(posedge clk_i);
      #1;
      req_valid_i   = 1'b0;
      req_opcode_i  = 4'($urandom);
      req_sew_i     = 2'($urandom);
      req_vl_i      = 4'($urandom);
      req_mask_en_i = 1'($urandom);
      req_mask_i    = 8'($urandom);
      req_op1_i     = rnd_vec();
      req_op2_i     = rnd_vec();
      lat = 0;
      while (!rsp_valid_o && lat < 40) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      chk_i({tag, " latency"}, lat, exp_lat);
      chk_v({tag, " result"}, rsp_result_o, exp);
      chk_i({tag, " error"}, int'(rsp_error_o), int'(err));
      for (int h = 0; h < hold; h++) begin
         req_valid_i = 1'b1;
         @(posedge clk_i);
         #1;
         chk_i({tag, " hold valid"}, int'(rsp_valid_o), 1);
         chk_i({tag, " hold ready"}, int'(req_ready_o), 0);
         chk_v({tag, " hold result"}, rsp_result_o, exp);
      end
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      rsp_ready_i = 1'b0;
      chk_i({tag, " post valid"}, int'(rsp_valid_o), 0);
      chk_i({tag, " post busy"}, int'(busy_o), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_ni        = 1'b0;
      req_valid_i   = 1'b0;
      req_opcode_i  = '0;
      req_sew_i     = '0;
      req_vl_i      = '0;
      req_mask_en_i = 1'b0;
      req_mask_i    = '0;
      req_op1_i     = '0;
      req_op2_i     = '0;
      rsp_ready_i   = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      chk_i("rst req_ready", int'(req_ready_o), 1);
      chk_i("rst rsp_valid", int'(rsp_valid_o), 0);
      chk_v("rst result", rsp_result_o, '0);
      chk_i("rst error", int'(rsp_error_o), 0);
      chk_i("rst busy", int'(busy_o), 0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      send("add32", 0, 2, 4, 0, 8'h00, mk(1, 2, 3, 4, 0, 0, 0, 0), mk(5, 6, 7, 8, 0, 0, 0, 0), 0);
      send("add8wrap", 0, 0, 1, 0, 8'h00, mk(32'h1234_00FF, 0, 0, 0, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0, 0, 0), 0);
      send("sub8", 1, 0, 1, 0, 8'h00, mk(0, 0, 0, 0, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0, 0, 0), 0);
      send("max8", 4, 0, 1, 0, 8'h00, mk(32'h7F, 0, 0, 0, 0, 0, 0, 0), mk(32'h80, 0, 0, 0, 0, 0, 0, 0), 0);
      send("min8", 3, 0, 1, 0, 8'h00, mk(32'h7F, 0, 0, 0, 0, 0, 0, 0), mk(32'h80, 0, 0, 0, 0, 0, 0, 0), 0);
      send("mul16", 2, 1, 3, 0, 8'h00, mk(300, 32'hFFFF, 7, 0, 0, 0, 0, 0), mk(300, 2, 9, 0, 0, 0, 0, 0), 0);
      send("maskadd", 0, 2, 4, 1, 8'b0101, mk(10, 20, 30, 40, 0, 0, 0, 0), mk(1, 1, 1, 1, 1, 1, 1, 1), 0);
      send("redmin", 9, 2, 5, 0, 8'h00, mk(5, 2, 8, 32'hFFFF_FFFF, 9, 0, 0, 0), rnd_vec(), 0);
      send("redsum", 8, 2, 4, 1, 8'b1011, mk(1, 2, 3, 4, 0, 0, 0, 0), rnd_vec(), 0);
      send("redmax0", 10, 2, 4, 1, 8'h00, mk(1, 2, 3, 4, 0, 0, 0, 0), rnd_vec(), 0);
      send("redmax8", 10, 0, 7, 0, 8'h00, mk(3, 32'hF0, 32'h81, 32'h7E, 5, 32'hFF, 1, 9), rnd_vec(), 0);
      send("permute", 11, 2, 4, 0, 8'h00, mk(32'hAA, 32'hBB, 32'hCC, 32'hDD, 0, 0, 0, 0), mk(3, 1, 0, 9, 0, 0, 0, 0), 0);
      send("badop", 15, 2, 4, 0, 8'h00, rnd_vec(), rnd_vec(), 0);
      send("vl9", 0, 2, 9, 0, 8'h00, rnd_vec(), rnd_vec(), 0);
      send("badsew", 0, 3, 2, 0, 8'h00, rnd_vec(), rnd_vec(), 0);
      send("vl0", 0, 2, 0, 0, 8'h00, rnd_vec(), rnd_vec(), 0);
      send("bpress", 7, 1, 8, 0, 8'h00, rnd_vec(), rnd_vec(), 5);

      // Reset while in EXEC discards the operation.
      req_valid_i  = 1'b1;
      req_opcode_i = 4'h0;
      req_sew_i    = 2'b10;
      req_vl_i     = 4'd8;
      req_op1_i    = rnd_vec();
      req_op2_i    = rnd_vec();
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      chk_i("exec busy", int'(busy_o), 1);
      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      chk_i("exec rst valid", int'(rsp_valid_o), 0);
      chk_i("exec rst ready", int'(req_ready_o), 1);
      chk_i("exec rst busy", int'(busy_o), 0);
      chk_v("exec rst result", rsp_result_o, '0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      for (int k = 0; k < 40; k++) begin
         int            op, sew, vl;
         logic [VW-1:0] a, b;
         op  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 15)) : int'($urandom_range(0, 11));
         sew = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
         vl  = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 8));
         a   = rnd_vec();
         b   = rnd_vec();
         if (op == 11)
            for (int i = 0; i < MAX_VL; i++) b[i*32 +: 32] = $urandom_range(0, 9);
         send($sformatf("rnd%0d", k), op, sew, vl, 1'($urandom), 8'($urandom), a, b,
              int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
